// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } conv_state_t;

  localparam int          DIGIT_W        = 4;
  localparam logic [3:0]  ADJ_THRESH     = 4'd5;
  localparam logic [3:0]  ADJ_ADD        = 4'd3;
  localparam logic [3:0]  DIGIT_DISABLED = 4'hF;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction, +3 when the digit is 5 or more
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // 4-bit wrap-around add; digits of a valid BCD accumulator never exceed 9
  assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - bit-serial binary-to-BCD converter with valid/ready on both sides
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      ovf
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W < 1) ? 1 : $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if (BIN_W < 1 || BIN_W > 32 || DIGITS < 1) begin : g_bad_param
    $error("bin_to_bcd_seq: BIN_W must be 1..32 and DIGITS at least 1");
  end

  conv_state_t      state, state_nxt;
  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_shift;
  logic             ovf_acc;
  logic             ovf_shift;
  logic [CNT_W-1:0] cnt;
  logic             last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[g*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // A set MSB in the adjusted top digit would be shifted out: the value cannot fit
  assign acc_shift = {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
  assign ovf_shift = ovf_acc | acc_adj[BCD_W-1];
  assign last      = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg   <= bin_in;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
          end
        end
        S_SHIFT: begin
          shreg   <= shreg << 1;
          acc     <= acc_shift;
          ovf_acc <= ovf_shift;
          cnt     <= cnt + 1'b1;
          // Result registers load on the final shift so they are valid on DONE entry
          if (last) begin
            bcd_out <= ovf_shift ? {DIGITS{DIGIT_DISABLED}} : acc_shift;
            ovf     <= ovf_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
